// File: rtl/regfile_sb_pkg.sv
// ============================================================================
// Module      : regfile_sb_pkg
// Description : Shared defaults and helpers for the scoreboarded register file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_sb_pkg;

    localparam int unsigned C_DEF_DATA_W   = 32;
    localparam int unsigned C_DEF_ADDR_W   = 5;
    localparam int unsigned C_DEF_INIT_CNT = 8;
    localparam int unsigned C_DEF_BYPASS   = 1;

    // Number of byte lanes in a register of the given width.
    function automatic int unsigned lane_cnt(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module      : rf_read_port
// Description : One read port: zero check, WB bypass with byte merge, and
//               busy generation from the pending scoreboard bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W = C_DEF_DATA_W,
    parameter int unsigned ADDR_W = C_DEF_ADDR_W,
    parameter int unsigned BYPASS = C_DEF_BYPASS
) (
    input  logic [ADDR_W-1:0]          rn,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wn,
    input  logic [DATA_W-1:0]          d,
    input  logic [lane_cnt(DATA_W)-1:0] wbe,
    input  logic [DATA_W-1:0]          rd_stored,
    input  logic                       pend_bit,
    output logic [DATA_W-1:0]          q,
    output logic                       busy
);

    localparam int unsigned LANES = lane_cnt(DATA_W);

    logic              hit;
    logic [DATA_W-1:0] merged;

    // Bypass detection, byte merge of the in-flight write, and output select.
    always_comb begin
        hit    = (BYPASS != 0) && we && (wn == rn) && (rn != '0);
        merged = rd_stored;
        for (int k = 0; k < int'(LANES); k++) begin
            if (wbe[k]) begin
                merged[8*k +: 8] = d[8*k +: 8];
            end
        end
        if (rn == '0) begin
            q = '0;
        end else if (hit) begin
            q = merged;
        end else begin
            q = rd_stored;
        end
        // A register being written this cycle is no longer outstanding when
        // its value is forwarded.
        busy = (rn != '0) && pend_bit && !hit;
    end

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : 2-read/1-write register file with byte-enable writes,
//               same-cycle WB bypass and a pending-write scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = C_DEF_DATA_W,
    parameter int unsigned ADDR_W   = C_DEF_ADDR_W,
    parameter int unsigned INIT_CNT = C_DEF_INIT_CNT,
    parameter int unsigned BYPASS   = C_DEF_BYPASS
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [ADDR_W-1:0]             rna,
    input  logic [ADDR_W-1:0]             rnb,
    output logic [DATA_W-1:0]             qa,
    output logic [DATA_W-1:0]             qb,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             wn,
    input  logic [DATA_W-1:0]             d,
    input  logic [lane_cnt(DATA_W)-1:0]   wbe,
    input  logic                          iss,
    input  logic [ADDR_W-1:0]             iss_wn,
    output logic                          busy_a,
    output logic                          busy_b,
    output logic [(2**ADDR_W)-1:0]        pend
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned LANES = lane_cnt(DATA_W);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    // Next-state: byte-masked WB write, then scoreboard clear-before-set so a
    // same-cycle reissue of the written register stays pending.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (wn != '0)) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (wbe[k]) begin
                    regs_d[wn][8*k +: 8] = d[8*k +: 8];
                end
            end
        end
        regs_d[0] = '0;

        pend_d = pend_q;
        if (we && (wn != '0)) begin
            pend_d[wn] = 1'b0;
        end
        if (iss && (iss_wn != '0)) begin
            pend_d[iss_wn] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // State registers; reset loads reg[i] = i for the first INIT_CNT registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= (i >= 1 && i <= int'(INIT_CNT)) ? DATA_W'(i) : '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_a (
        .rn        (rna),
        .we        (we),
        .wn        (wn),
        .d         (d),
        .wbe       (wbe),
        .rd_stored (regs_q[rna]),
        .pend_bit  (pend_q[rna]),
        .q         (qa),
        .busy      (busy_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_b (
        .rn        (rnb),
        .we        (we),
        .wn        (wn),
        .d         (d),
        .wbe       (wbe),
        .rd_stored (regs_q[rnb]),
        .pend_bit  (pend_q[rnb]),
        .q         (qb),
        .busy      (busy_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb (BYPASS=1 and 0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    logic        clk;
    logic        clrn;
    logic [4:0]  rna, rnb, wn, iss_wn;
    logic        we, iss;
    logic [31:0] d;
    logic [3:0]  wbe;

    logic [31:0] qa1, qb1, qa0, qb0;
    logic        busy_a1, busy_b1, busy_a0, busy_b0;
    logic [31:0] pend1, pend0;

    int checks;
    int errors;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .INIT_CNT(8), .BYPASS(1)) dut_b1 (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
        .we(we), .wn(wn), .d(d), .wbe(wbe), .iss(iss), .iss_wn(iss_wn),
        .busy_a(busy_a1), .busy_b(busy_b1), .pend(pend1)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .INIT_CNT(8), .BYPASS(0)) dut_b0 (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
        .we(we), .wn(wn), .d(d), .wbe(wbe), .iss(iss), .iss_wn(iss_wn),
        .busy_a(busy_a0), .busy_b(busy_b0), .pend(pend0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        we = 1'b0; wn = 5'd0; d = 32'd0; wbe = 4'h0;
        iss = 1'b0; iss_wn = 5'd0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        idle_inputs();
        rna = 5'd0; rnb = 5'd0;
        clrn = 1'b0;
        #12;
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            rna = 5'(i);
            #1;
            exp = (i <= 8) ? 32'(i) : 32'd0;
            checks++;
            if (qa1 !== exp) begin
                errors++;
                $display("FAIL reset_qa reg%0d got %h want %h", i, qa1, exp);
            end
        end
        checks++;
        if (pend1 !== 32'd0 || pend0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_pend got %h/%h want 0", pend1, pend0);
        end
        checks++;
        if (busy_a1 !== 1'b0 || busy_b1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b%b want 00", busy_a1, busy_b1);
        end
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        we = 1'b1; wn = 5'd5; d = 32'hAABBCCDD; wbe = 4'b0101;
        rna = 5'd5;
        #1;
        checks++;
        if (qa1 !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL byte_bypass got %h want %h", qa1, 32'h00BB00DD);
        end
        checks++;
        if (qa0 !== 32'h00000005) begin
            errors++;
            $display("FAIL byte_nobypass got %h want %h", qa0, 32'h00000005);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (qa1 !== 32'h00BB00DD || qa0 !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL byte_write got %h/%h want %h", qa1, qa0, 32'h00BB00DD);
        end
        // Upper-lane-only write keeps bytes 0 and 2.
        we = 1'b1; wn = 5'd5; d = 32'h11223344; wbe = 4'b1010;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (qa1 !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_write2 got %h want %h", qa1, 32'h11BB33DD);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; wn = 5'd7; d = 32'h12345678; wbe = 4'hF;
        rna = 5'd7; rnb = 5'd7;
        #1;
        checks++;
        if (qa1 !== 32'h12345678 || qb1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_on got %h/%h want %h", qa1, qb1, 32'h12345678);
        end
        checks++;
        if (qa0 !== 32'h00000007) begin
            errors++;
            $display("FAIL bypass_off got %h want %h", qa0, 32'h00000007);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (qa0 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_after got %h want %h", qa0, 32'h12345678);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        we = 1'b1; wn = 5'd0; d = 32'hFFFFFFFF; wbe = 4'hF;
        iss = 1'b1; iss_wn = 5'd0; rna = 5'd0;
        #1;
        checks++;
        if (qa1 !== 32'd0 || busy_a1 !== 1'b0) begin
            errors++;
            $display("FAIL reg0_pre got %h busy %b want 0 busy 0", qa1, busy_a1);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (qa1 !== 32'd0 || qa0 !== 32'd0 || pend1[0] !== 1'b0 || busy_a1 !== 1'b0) begin
            errors++;
            $display("FAIL reg0_post got %h/%h pend0 %b busy %b want 0", qa1, qa0, pend1[0], busy_a1);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss = 1'b1; iss_wn = 5'd9; rnb = 5'd9;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (pend1 !== 32'h00000200 || busy_b1 !== 1'b1 || busy_b0 !== 1'b1) begin
            errors++;
            $display("FAIL sb_set got pend %h busy %b%b want 00000200 busy 11", pend1, busy_b1, busy_b0);
        end
        // Reissue to an already-pending register keeps a single pending bit.
        iss = 1'b1; iss_wn = 5'd9;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        we = 1'b1; wn = 5'd9; d = 32'hCAFEF00D; wbe = 4'hF;
        #1;
        checks++;
        if (busy_b1 !== 1'b0 || qb1 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL sb_wb_b1 got busy %b q %h want busy 0 q cafef00d", busy_b1, qb1);
        end
        checks++;
        if (busy_b0 !== 1'b1 || qb0 !== 32'd0) begin
            errors++;
            $display("FAIL sb_wb_b0 got busy %b q %h want busy 1 q 0", busy_b0, qb0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (pend1 !== 32'd0 || pend0 !== 32'd0 || busy_b1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear got %h/%h busy %b want 0", pend1, pend0, busy_b1);
        end
        // A write with no byte enables still clears the pending bit.
        iss = 1'b1; iss_wn = 5'd3; rna = 5'd3;
        @(negedge clk);
        idle_inputs();
        we = 1'b1; wn = 5'd3; d = 32'hFFFFFFFF; wbe = 4'h0;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (pend1 !== 32'd0 || qa1 !== 32'd3) begin
            errors++;
            $display("FAIL sb_wbe0 got pend %h q %h want pend 0 q 3", pend1, qa1);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        iss = 1'b1; iss_wn = 5'd4;
        we = 1'b1; wn = 5'd4; d = 32'h00000044; wbe = 4'hF;
        rna = 5'd4;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (pend1 !== 32'h00000010 || qa1 !== 32'h00000044 || busy_a1 !== 1'b1) begin
            errors++;
            $display("FAIL collision got pend %h q %h busy %b want 00000010 44 1", pend1, qa1, busy_a1);
        end
    endtask

    task automatic test_midreset();
        @(negedge clk);
        we = 1'b1; wn = 5'd6; d = 32'hDEADBEEF; wbe = 4'hF;
        iss = 1'b1; iss_wn = 5'd10;
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if (pend1 !== 32'd0 || pend0 !== 32'd0) begin
            errors++;
            $display("FAIL midreset_pend got %h/%h want 0", pend1, pend0);
        end
        @(posedge clk);
        #2;
        idle_inputs();
        clrn = 1'b1;
        rna = 5'd6; rnb = 5'd5;
        #1;
        checks++;
        if (qa1 !== 32'd6 || qb1 !== 32'd5) begin
            errors++;
            $display("FAIL midreset_regs got %h/%h want 6/5", qa1, qb1);
        end
        rna = 5'd7; rnb = 5'd4;
        #1;
        checks++;
        if (qa0 !== 32'd7 || qb0 !== 32'd4 || busy_b0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_regs2 got %h/%h busy %b want 7/4 0", qa0, qb0, busy_b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rna = 5'd0; rnb = 5'd0;
        clrn = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_write();
        test_bypass();
        test_reg0();
        test_scoreboard();
        test_collision();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
